// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI link pins shared between master and responder
//
// Purpose: bundles the four SPI wires so the master side (testbench or a
// real master) and the responder side connect through one port.
// Signals:
//   sclk  serial clock, driven by the master
//   cs    chip select, active low, driven by the master
//   mosi  master-to-responder serial data
//   miso  responder-to-master serial data (may be Z when shared)
interface spi_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 responder, oversampled on the system clock
//
// Purpose: receives MSB-first bytes on mosi and returns the buffered
// transmit byte on miso in the same transfer. sclk/cs/mosi are brought into
// the clk domain through two-flop synchronizers; a third flop on sclk and cs
// provides edge detection.
// Ports:
//   clk       system clock, all flops on its rising edge
//   reset     asynchronous, active-high reset
//   tx_data   byte to return to the master
//   tx_load   writes tx_data into the transmit buffer
//   rx_data   last complete received byte
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      high while synchronized cs is low
//   spi       SPI pins (slave modport)
// Build option: SPI_SLAVE_MISO_TRISTATE_EN makes miso 1'bz while idle/reset.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  spi_slave_if.slave            spi
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  byte_done_q, byte_done_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;

  always_comb begin
    state_d     = state_q;
    tx_buf_d    = tx_load ? tx_data : tx_buf_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d   = '0;
        byte_done_d = 1'b0;
        if (cs_fall) begin
          // shift_tx takes the buffer value before any same-cycle tx_load
          state_d    = SHIFT;
          shift_tx_d = tx_buf_q;
          shift_rx_d = '0;
        end
      end
      SHIFT: begin
        if (cs_s2_q) begin
          // cs released: any partial byte is simply dropped
          state_d     = IDLE;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
        end else begin
          // Completion is handled one cycle after the count reaches
          // DATA_WIDTH, so rx_valid lands on the 4th clk edge after sclk rise.
          if (bit_cnt_q == CW'(DATA_WIDTH)) begin
            rx_data_d   = shift_rx_q;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
          end else if (sclk_rise) begin
            shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_s2_q};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) begin
            if (bit_cnt_q == '0 && byte_done_q) begin
              // Back-to-back byte: present the buffer for the next byte
              shift_tx_d  = tx_buf_q;
              byte_done_d = 1'b0;
            end else begin
              shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      // cs edge flop resets high so a held-low cs still yields a falling edge
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= IDLE;
      tx_buf_q    <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      sclk_s1_q   <= spi.sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= spi.cs;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= spi.mosi;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = ~cs_s2_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign spi.miso = (state_q == SHIFT) ? shift_tx_q[DATA_WIDTH-1] : 1'bz;
`else
  assign spi.miso = (state_q == SHIFT) ? shift_tx_q[DATA_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_load;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;

  spi_slave_if spi ();

  spi_slave #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi      (spi)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  model_buf;
  logic [7:0]  rx_obs[$];
  logic [7:0]  rx_exp[$];

  always @(negedge clk) if (rx_valid === 1'b1) rx_obs.push_back(rx_data);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_buf(input logic [7:0] v);
    tx_data = v; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
    model_buf = v;
  endtask

  task automatic cs_low();
    spi.cs = 1'b0; cyc(5);
  endtask

  task automatic cs_high();
    cyc(5); spi.cs = 1'b1; cyc(6);
  endtask

  // Master side of nbits of one byte: mosi set during low phase, miso read at rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_load,
                      input logic [7:0] lv, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = mo[7-i];
      if (do_load && i == 3) begin
        tx_data = lv; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
        model_buf = lv;
        cyc(4);
      end else begin
        cyc(5);
      end
      spi.sclk = 1'b1;
      mi[7-i] = spi.miso;
      cyc(5);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic exp_miso;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    exp_miso = 1'bz;
`else
    exp_miso = 1'b0;
`endif
    reset = 1'b1; tx_load = 1'b0; tx_data = '0;
    spi.cs = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
    cyc(3);
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (spi.miso !== exp_miso) begin n_err++; $display("FAIL reset_miso: got %b want %b", spi.miso, exp_miso); end
    reset = 1'b0;
    model_buf = 8'h00;
    cyc(3);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi, e;
    rx_obs.delete();
    load_buf(8'h3C);
    e = model_buf;
    cs_low();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    xfer(8'hAA, 8, 1'b0, 8'h00, mi);
    cs_high();
    n_vec++; if (mi !== e) begin n_err++; $display("FAIL single_miso: got %h want %h", mi, e); end
    n_vec++; if (rx_obs.size() != 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", rx_obs.size()); end
    else if (rx_obs[0] !== 8'hAA) begin n_err++; $display("FAIL single_rx: got %h want aa", rx_obs[0]); end
    n_vec++; if (rx_data !== 8'hAA) begin n_err++; $display("FAIL single_rx_hold: got %h want aa", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2, e1, e2;
    rx_obs.delete();
    cs_low();
    e1 = model_buf;
    xfer(8'h5A, 8, 1'b1, 8'h81, m1);
    e2 = model_buf;
    xfer(8'hC3, 8, 1'b0, 8'h00, m2);
    cs_high();
    n_vec++; if (m1 !== e1) begin n_err++; $display("FAIL b2b_miso1: got %h want %h", m1, e1); end
    n_vec++; if (m2 !== e2) begin n_err++; $display("FAIL b2b_miso2: got %h want %h", m2, e2); end
    n_vec++; if (rx_obs.size() != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", rx_obs.size()); end
    else if (rx_obs[0] !== 8'h5A || rx_obs[1] !== 8'hC3) begin
      n_err++; $display("FAIL b2b_rx: got %h %h want 5a c3", rx_obs[0], rx_obs[1]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi, e;
    rx_obs.delete();
    cs_low();
    xfer(8'($urandom), 4, 1'b0, 8'h00, mi);
    cs_high();
    n_vec++; if (rx_obs.size() != 0) begin n_err++; $display("FAIL abort_pulses: got %0d want 0", rx_obs.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    e = model_buf;
    cs_low();
    xfer(8'hF0, 8, 1'b0, 8'h00, mi);
    cs_high();
    n_vec++; if (mi !== e) begin n_err++; $display("FAIL abort_next_miso: got %h want %h", mi, e); end
    n_vec++; if (rx_obs.size() != 1) begin n_err++; $display("FAIL abort_next_pulses: got %0d want 1", rx_obs.size()); end
    else if (rx_obs[0] !== 8'hF0) begin n_err++; $display("FAIL abort_next_rx: got %h want f0", rx_obs[0]); end
  endtask

  task automatic test_async_reset();
    logic [7:0] mi;
    rx_obs.delete();
    cs_low();
    xfer(8'($urandom), 5, 1'b0, 8'h00, mi);
    cyc(2);
    reset = 1'b1;
    #1;
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL areset_rx_data: got %h want 00", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
    cyc(2);
    reset = 1'b0;
    model_buf = 8'h00;
    cyc(4);
    spi.cs = 1'b1;
    cyc(6);
    n_vec++; if (rx_obs.size() != 0) begin n_err++; $display("FAIL areset_pulses: got %0d want 0", rx_obs.size()); end
    cs_low();
    xfer(8'h11, 8, 1'b0, 8'h00, mi);
    cs_high();
    n_vec++; if (mi !== model_buf) begin n_err++; $display("FAIL areset_miso: got %h want %h", mi, model_buf); end
    n_vec++; if (rx_obs.size() != 1) begin n_err++; $display("FAIL areset_next_pulses: got %0d want 1", rx_obs.size()); end
    else if (rx_obs[0] !== 8'h11) begin n_err++; $display("FAIL areset_next_rx: got %h want 11", rx_obs[0]); end
  endtask

  task automatic test_same_cycle_load();
    logic [7:0] m1, m2, e1, r1, r2;
    rx_obs.delete();
    load_buf(8'h00);
    e1 = model_buf;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    // cs pin falls; the responder loads shift_tx on the 3rd clk edge after it
    spi.cs = 1'b0;
    cyc(2);
    tx_data = 8'hFF; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
    model_buf = 8'hFF;
    cyc(2);
    xfer(r1, 8, 1'b0, 8'h00, m1);
    xfer(r2, 8, 1'b0, 8'h00, m2);
    cs_high();
    n_vec++; if (m1 !== e1) begin n_err++; $display("FAIL same_cycle_miso1: got %h want %h", m1, e1); end
    n_vec++; if (m2 !== 8'hFF) begin n_err++; $display("FAIL same_cycle_miso2: got %h want ff", m2); end
    n_vec++; if (rx_obs.size() != 2) begin n_err++; $display("FAIL same_cycle_pulses: got %0d want 2", rx_obs.size()); end
    else if (rx_obs[0] !== r1 || rx_obs[1] !== r2) begin
      n_err++; $display("FAIL same_cycle_rx: got %h %h want %h %h", rx_obs[0], rx_obs[1], r1, r2);
    end
  endtask

  task automatic test_random();
    logic [7:0] mo, mi, e, lv;
    int nb;
    bit dl;
    for (int t = 0; t < 8; t++) begin
      rx_obs.delete();
      rx_exp.delete();
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) load_buf(8'($urandom));
      cs_low();
      for (int b = 0; b < nb; b++) begin
        mo = 8'($urandom);
        dl = 1'($urandom_range(0, 1));
        lv = 8'($urandom);
        e  = model_buf;
        xfer(mo, 8, dl, lv, mi);
        rx_exp.push_back(mo);
        n_vec++; if (mi !== e) begin n_err++; $display("FAIL rand_miso t%0d b%0d: got %h want %h", t, b, mi, e); end
      end
      cs_high();
      n_vec++;
      if (rx_obs.size() != rx_exp.size()) begin
        n_err++; $display("FAIL rand_pulses t%0d: got %0d want %0d", t, rx_obs.size(), rx_exp.size());
      end else begin
        for (int k = 0; k < rx_exp.size(); k++) begin
          if (rx_obs[k] !== rx_exp[k]) begin
            n_err++; $display("FAIL rand_rx t%0d b%0d: got %h want %h", t, k, rx_obs[k], rx_exp[k]);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_same_cycle_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Responder end of the team's SPI link: receives serial bytes from the SPI master on `mosi` and returns a preloaded byte on `miso` in the same transfer. It runs on the local system clock and oversamples the master's `sclk`, `cs` and `mosi` through two-flop synchronizers. The link uses SPI mode 0 (CPOL=0, CPHA=0), MSB first, with active-low `cs`. Received bytes go to local logic as a one-cycle `rx_valid` pulse.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer; also the width of `tx_data` and `rx_data`.
- `clk` input 1: system clock; every flop is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tx_data` input DATA_WIDTH: byte to return to the master.
- `tx_load` input 1: when high, `tx_data` is written into the transmit buffer on that clk edge.
- `rx_data` output DATA_WIDTH: last complete received byte; held until the next complete byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: high while synchronized `cs` is low.
- `sclk` input 1: serial clock from the master, asynchronous to `clk`.
- `cs` input 1: chip select from the master, active low, asynchronous.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master.

## Operation
- Synchronizers: 2 flops each on `sclk`, `cs`, `mosi`. Reset values: sclk=0, cs=1, mosi=0. A third flop on `sclk` and on `cs` provides edge detection.
- FSM states:
  - IDLE: synchronized `cs` is high.
  - SHIFT: `cs` is low.
  - Any state goes to IDLE when synchronized `cs` is high.
- IDLE to SHIFT on a `cs` falling edge:
  - shift_tx loads the transmit buffer; `miso` presents its MSB.
  - bit_cnt clears; shift_rx clears.
- In SHIFT, on a synchronized `sclk` rising edge:
  - shift_rx becomes {shift_rx[DATA_WIDTH-2:0], mosi_sync}; bit_cnt increments.
- In SHIFT, on a synchronized `sclk` falling edge:
  - shift_tx shifts left by one and `miso` shows the new MSB.
  - Exception: if bit_cnt is 0 and a byte has just completed, shift_tx reloads from the transmit buffer instead (back-to-back byte).
- Byte completion, on the rising edge that makes bit_cnt equal DATA_WIDTH:
  - `rx_data` takes the completed shift value and `rx_valid` pulses for one cycle.
  - bit_cnt wraps to 0.
- Abort: `cs` rising while bit_cnt is nonzero discards the partial byte. No `rx_valid` is produced; go to IDLE.
- Transmit buffer:
  - Written only by `tx_load`. Never cleared by a transfer, so the same byte repeats unless it is reloaded.
  - If `tx_load` arrives in the same cycle as a load of shift_tx, shift_tx takes the old buffer value. The new value applies to the next byte.
- `sclk` edges while IDLE are ignored.
- `mosi` is sampled only on rising edges. `miso` changes only on `sclk` falling edges or on `cs` falling.
- bit_cnt is $clog2(DATA_WIDTH)+1 bits wide.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `busy`=0, transmit buffer=0, shift registers=0, bit_cnt=0, FSM=IDLE. `miso`=0, or Z per Configuration.
- Pin edge to internal action: 3 clk cycles (2 synchronizer stages plus 1 edge-detect stage).
- Rising edge to `rx_valid` for the last bit: `rx_valid` asserts on the 4th clk edge after the `sclk` rise.
- Constraint: each `sclk` high and low phase is at least 4 clk periods. `cs` falls at least 4 clk periods before the first `sclk` rise and rises at least 4 clk periods after the last `sclk` fall.
- `busy` follows synchronized `cs` with 2-cycle latency.
- Asynchronous `reset` mid-transfer: the block enters the reset state immediately.
  - The transfer in progress is lost.
  - After reset releases, the block waits for a fresh `cs` falling edge, even if `cs` is still low. The `cs` edge-detect flop resets to 1, so a held-low `cs` does produce a falling edge once the synchronizer fills.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN` defined: `miso` is 1'bz whenever the FSM is IDLE and during reset, so several slaves can share one `miso` wire.
- Not defined: `miso` is driven 0 in IDLE and during reset.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `reset` with `cs`=1 → `rx_data`=0, `rx_valid`=0, `busy`=0, `miso`=0. In the macro build, `miso`=Z.
- Single byte:
  - Stimulus: `tx_load` with `tx_data`=8'h3C; master sends 8'b10101010 in mode 0 with `sclk` period 10 clk.
  - Response: `rx_data`=8'hAA with exactly one `rx_valid` pulse; `miso` sampled on `sclk` rises reads 0,0,1,1,1,1,0,0.
- Back-to-back: `cs` held low, master sends 8'h5A then 8'hC3, `tx_load` 8'h81 during byte 1.
  - `rx_valid` pulses twice, with `rx_data` 8'h5A then 8'hC3.
  - `miso` returns the first buffered byte, then 8'h81.
- Abort: `cs` rises after 4 `sclk` cycles → no `rx_valid`; `busy` falls. The next full transfer of 8'hF0 gives `rx_data`=8'hF0.
- Async reset: `reset` pulsed after 5 bits with `cs` still low → no `rx_valid` for that byte. A new `cs` cycle sending 8'h11 then gives `rx_data`=8'h11.
- Same-cycle load: `tx_load` 8'hFF coincides with the `cs` fall, buffer previously 8'h00 → the first byte on `miso` is 8'h00 and the second is 8'hFF.
